// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction-fetch stage controller. It owns the program counter and the
// IF/ID pipeline register, and sequences fetch through three states:
//   WAIT - one idle cycle after reset release; nothing is latched.
//   RUN  - fetches sequentially and accepts jump / branch redirects.
//   HALT - PC frozen, bubbles fed into IF/ID, redirects ignored.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   Instruction_addr   byte address to instruction memory (= current PC)
//   Instruction_Data   combinational read data for Instruction_addr
//   stall              hazard-unit stall request
//   branch_taken/_target, jump/jump_target
//                      redirect requests; jump has priority over branch
//   halt_req, resume   stop / restart fetching
//   IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid
//                      IF/ID pipeline register
//   fetch_state        00 WAIT, 01 RUN, 10 HALT
//   align_err          sticky flag: an accepted redirect target was misaligned
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int                      ADDR_SIZE = 32,
  parameter int                      MEM_WIDTH = 32,
  parameter int                      MEM_DEPTH = 1024,
  parameter logic [ADDR_SIZE-1:0]    RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDR_SIZE-1:0] Instruction_addr,
  input  logic [MEM_WIDTH-1:0] Instruction_Data,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [ADDR_SIZE-1:0] branch_target,
  input  logic                 jump,
  input  logic [ADDR_SIZE-1:0] jump_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [MEM_WIDTH-1:0] IF_ID_instr,
  output logic [ADDR_SIZE-1:0] IF_ID_pc_plus4,
  output logic                 IF_ID_valid,
  output logic [1:0]           fetch_state,
  output logic                 align_err
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // First byte address past the end of instruction memory. One extra bit so
  // that a PC+4 which wraps past 2^ADDR_SIZE still compares as out of range.
  localparam logic [ADDR_SIZE:0] PC_LIMIT = (ADDR_SIZE+1)'(MEM_DEPTH) << 2;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [MEM_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_SIZE-1:0]   pc4_q, pc4_d;
  logic                   valid_q, valid_d;
  logic                   align_q, align_d;

  logic [ADDR_SIZE:0]     pc_plus4_wide;
  logic [ADDR_SIZE-1:0]   pc_plus4;
  logic                   seq_out_of_range;
  logic                   redirect;
  logic [ADDR_SIZE-1:0]   redirect_target;

  // Carry-preserving increment: the low ADDR_SIZE bits are the wrapped PC+4,
  // the full width is what gets compared against the memory limit.
  assign pc_plus4_wide    = {1'b0, pc_q} + (ADDR_SIZE+1)'(4);
  assign pc_plus4         = pc_plus4_wide[ADDR_SIZE-1:0];
  assign seq_out_of_range = (pc_plus4_wide >= PC_LIMIT);

  assign redirect         = jump | branch_taken;
  assign redirect_target  = jump ? jump_target : branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    align_d = align_q;

    case (state_q)
      ST_WAIT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect) begin
          // Redirect wins over stall and over halt_req; a simultaneous
          // halt_req still lands the target in PC before halting.
          pc_d    = {redirect_target[ADDR_SIZE-1:2], 2'b00};
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            align_d = 1'b1;
          end
          if (halt_req) begin
            state_d = ST_HALT;
          end
        end else if (halt_req) begin
          // PC stays on the unfetched instruction so resume re-fetches it.
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (stall) begin
          // Hold PC and IF/ID (defaults).
        end else begin
          instr_d = Instruction_Data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // The current word is still a legal fetch; only the step past the
          // end of memory is refused, so PC parks on the last word.
          if (seq_out_of_range) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (resume && !halt_req) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      align_q <= align_d;
    end
  end

  assign Instruction_addr = pc_q;
  assign IF_ID_instr      = instr_q;
  assign IF_ID_pc_plus4   = pc4_q;
  assign IF_ID_valid      = valid_q;
  assign fetch_state      = state_q;
  assign align_err        = align_q;

endmodule
